// File: rtl/reset_sequencer.sv
// reset_sequencer: async-assert/sync-deassert reset with held, staggered per-channel release
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_rst_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             rst_done
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t           state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic             sync_ok;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [N_OUT-1:0] rst_out_n;
  logic             rst_done_n;
  assign sync_ok = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= '0;
      state    <= HOLD;
      cnt      <= '0;
      idx      <= '0;
      rst_out  <= '1;
      rst_done <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], 1'b1};
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      rst_out  <= rst_out_n;
      rst_done <= rst_done_n;
    end
  end
  // Software request dominates every state; in HOLD it simply restarts the hold count.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    rst_out_n  = rst_out;
    rst_done_n = rst_done;
    if (sw_rst_req) begin
      state_n    = HOLD;
      cnt_n      = '0;
      idx_n      = '0;
      rst_out_n  = '1;
      rst_done_n = 1'b0;
    end else begin
      case (state)
        HOLD: if (sync_ok) begin
          if (cnt == HOLD_LAST) begin
            cnt_n      = '0;
            idx_n      = IW'(1);
            rst_out_n  = rst_out & ~N_OUT'(1);
            state_n    = N_OUT == 1 ? RUN : RELEASE;
            rst_done_n = N_OUT == 1;
          end else cnt_n = cnt + CW'(1);
        end
        RELEASE: if (cnt == GAP_LAST) begin
          cnt_n      = '0;
          idx_n      = idx + IW'(1);
          rst_out_n  = rst_out & ~(N_OUT'(1) << idx);
          state_n    = idx == IDX_LAST ? RUN : RELEASE;
          rst_done_n = idx == IDX_LAST;
        end else cnt_n = cnt + CW'(1);
        RUN: ;
        default: state_n = HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized check of two configurations against a release-schedule model
module tb_reset_sequencer;
  localparam int SA = 2, NA = 4, HA = 16, GA = 4;
  localparam int SB = 3, NB = 1, HB = 1, GB = 1;
  logic clk = 1'b0;
  logic reset, sw_rst_req;
  logic [NA-1:0] rst_out_a;
  logic [NB-1:0] rst_out_b;
  logic rst_done_a, rst_done_b;
  int total = 0, bad = 0;
  int n = 0, base_a = SA + HA, base_b = SB + HB;
  always #5 clk = ~clk;
  reset_sequencer #(.SYNC_STAGES(SA), .N_OUT(NA), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) u_a (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .rst_out(rst_out_a), .rst_done(rst_done_a));
  reset_sequencer #(.SYNC_STAGES(SB), .N_OUT(NB), .HOLD_CYCLES(HB), .GAP_CYCLES(GB)) u_b (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .rst_out(rst_out_b), .rst_done(rst_done_b));
  // n counts edges since the board reset lifted; bit i drops once n reaches base + i*gap.
  function automatic logic [31:0] exp_out(int e, int b, int g, int w);
    logic [31:0] v = '0;
    for (int i = 0; i < w; i++) v[i] = e < b + i * g;
    return v;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t n=%0d got=%h exp=%h", tag, $time, n, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, "_out_a"}, 32'(rst_out_a), exp_out(n, base_a, GA, NA));
    check({tag, "_done_a"}, 32'(rst_done_a), 32'(n >= base_a + (NA - 1) * GA));
    check({tag, "_out_b"}, 32'(rst_out_b), exp_out(n, base_b, GB, NB));
    check({tag, "_done_b"}, 32'(rst_done_b), 32'(n >= base_b + (NB - 1) * GB));
  endtask
  task automatic restart_model();
    n = 0;
    base_a = SA + HA;
    base_b = SB + HB;
  endtask
  task automatic step(input logic s, input logic r);
    sw_rst_req = s;
    reset = r;
    if (!r) begin
      restart_model();
      #1 check_all("async");
    end
    @(posedge clk);
    if (r) begin
      n++;
      if (s) begin
        base_a = (n > SA ? n : SA) + HA;
        base_b = (n > SB ? n : SB) + HB;
      end
    end
    @(negedge clk);
    check_all("edge");
  endtask
  task automatic glitch();
    sw_rst_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    n++;
    #2 reset = 1'b0;
    #1 restart_model();
    check_all("glitch");
    #1 reset = 1'b1;
    @(negedge clk);
    check_all("post_glitch");
  endtask
  initial begin
    reset = 1'b1;
    sw_rst_req = 1'b0;
    #1 reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    repeat (34) step(1'b0, 1'b1);
    glitch();
    repeat (34) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (32) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (22) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (32) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (34) step(1'b0, 1'b1);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) glitch();
      else step($urandom_range(0, 24) == 0, $urandom_range(0, 59) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
